// File: rtl/ili9341_spi_controller.sv
// ILI9341 write-only 4-wire SPI driver: init sequence, window setup, then RGB565 pixel stream.
// Latency: 2 clk per bit, 16 clk per byte, 32 clk per pixel; data_clk requests the next pixel.
// Backpressure: none; upstream must present each pixel within 30 clk of its data_clk pulse.
// Build option: define ILI9341_FAST_SIM_EN to shorten both post-command waits to 16 cycles.
module ili9341_spi_controller #(
    parameter int PIXEL_SIZE   = 16,
    parameter int WIDTH        = 128,
    parameter int HEIGHT       = 128,
    parameter int SWRESET_WAIT = 100_000,
    parameter int SLPOUT_WAIT  = 2_400_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_done,
    input  logic [PIXEL_SIZE-1:0] input_data,
    output logic                  spi_mosi,
    output logic                  spi_sck,
    output logic                  spi_cs,
    output logic                  spi_dc,
    output logic                  data_clk
);

`ifdef ILI9341_FAST_SIM_EN
    localparam int RST_WAIT = 16;
    localparam int SLP_WAIT = 16;
`else
    localparam int RST_WAIT = SWRESET_WAIT;
    localparam int SLP_WAIT = SLPOUT_WAIT;
`endif

    localparam int MAX_WAIT = (RST_WAIT > SLP_WAIT) ? RST_WAIT : SLP_WAIT;
    localparam int WAIT_W   = $clog2(MAX_WAIT) + 1;

    localparam logic [WAIT_W-1:0] RST_LAST = WAIT_W'(RST_WAIT - 1);
    localparam logic [WAIT_W-1:0] SLP_LAST = WAIT_W'(SLP_WAIT - 1);

    localparam logic [15:0] COL_END  = 16'(WIDTH - 1);
    localparam logic [15:0] PAGE_END = 16'(HEIGHT - 1);

    // Index of the last configuration byte (RAMWR).
    localparam logic [3:0] CFG_LAST = 4'd15;

    typedef enum logic [2:0] {
        S_SWRESET,
        S_WAIT_RST,
        S_SLPOUT,
        S_WAIT_SLP,
        S_CONFIG,
        S_PRIME,
        S_PIXEL,
        S_DONE
    } state_t;

    state_t                  state;
    logic                    phase;      // 0: sck low / mosi update, 1: sck high
    logic [3:0]              bit_cnt;    // bit position within the current byte or pixel
    logic [3:0]              cfg_idx;    // position in the configuration table
    logic [WAIT_W-1:0]       wait_cnt;   // idle counter for waits, prime step flag
    logic [PIXEL_SIZE-1:0]   shreg;      // outgoing bits, MSB on the wire first
    logic                    pix_last;   // pixel being sent is the last of the frame

    logic [7:0]              cfg_byte;
    logic                    cfg_dc;
    logic [PIXEL_SIZE-1:0]   load_word;
    logic                    load_dc;
    logic [3:0]              last_bit;

    // Configuration table: pixel format, orientation, column/page window, display on, RAMWR.
    always_comb begin
        cfg_byte = 8'h00;
        cfg_dc   = 1'b1;
        case (cfg_idx)
            4'd0:  begin cfg_byte = 8'h3A;           cfg_dc = 1'b0; end
            4'd1:  begin cfg_byte = 8'h55;           cfg_dc = 1'b1; end
            4'd2:  begin cfg_byte = 8'h36;           cfg_dc = 1'b0; end
            4'd3:  begin cfg_byte = 8'h48;           cfg_dc = 1'b1; end
            4'd4:  begin cfg_byte = 8'h2A;           cfg_dc = 1'b0; end
            4'd5:  begin cfg_byte = 8'h00;           cfg_dc = 1'b1; end
            4'd6:  begin cfg_byte = 8'h00;           cfg_dc = 1'b1; end
            4'd7:  begin cfg_byte = COL_END[15:8];   cfg_dc = 1'b1; end
            4'd8:  begin cfg_byte = COL_END[7:0];    cfg_dc = 1'b1; end
            4'd9:  begin cfg_byte = 8'h2B;           cfg_dc = 1'b0; end
            4'd10: begin cfg_byte = 8'h00;           cfg_dc = 1'b1; end
            4'd11: begin cfg_byte = 8'h00;           cfg_dc = 1'b1; end
            4'd12: begin cfg_byte = PAGE_END[15:8];  cfg_dc = 1'b1; end
            4'd13: begin cfg_byte = PAGE_END[7:0];   cfg_dc = 1'b1; end
            4'd14: begin cfg_byte = 8'h29;           cfg_dc = 1'b0; end
            4'd15: begin cfg_byte = 8'h2C;           cfg_dc = 1'b0; end
            default: begin cfg_byte = 8'h00;         cfg_dc = 1'b1; end
        endcase
    end

    // Word loaded into the shift register at the first bit of each byte/pixel.
    // Single bytes sit left-justified so the shift path is common to all states.
    always_comb begin
        load_word = '0;
        load_dc   = 1'b0;
        last_bit  = 4'd7;
        case (state)
            S_SWRESET: begin
                load_word = {8'h01, {(PIXEL_SIZE-8){1'b0}}};
                load_dc   = 1'b0;
            end
            S_SLPOUT: begin
                load_word = {8'h11, {(PIXEL_SIZE-8){1'b0}}};
                load_dc   = 1'b0;
            end
            S_CONFIG: begin
                load_word = {cfg_byte, {(PIXEL_SIZE-8){1'b0}}};
                load_dc   = cfg_dc;
            end
            S_PIXEL: begin
                load_word = input_data;
                load_dc   = 1'b1;
                last_bit  = 4'd15;
            end
            default: begin
                load_word = '0;
                load_dc   = 1'b0;
                last_bit  = 4'd7;
            end
        endcase
    end

    // Sequencer, bit-level shifter and registered pin drivers in one state machine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_SWRESET;
            phase    <= 1'b0;
            bit_cnt  <= 4'd0;
            cfg_idx  <= 4'd0;
            wait_cnt <= '0;
            shreg    <= '0;
            pix_last <= 1'b0;
            spi_mosi <= 1'b0;
            spi_sck  <= 1'b0;
            spi_cs   <= 1'b1;
            spi_dc   <= 1'b0;
            data_clk <= 1'b0;
        end else begin
            data_clk <= 1'b0;
            case (state)
                S_SWRESET, S_SLPOUT, S_CONFIG, S_PIXEL: begin
                    spi_cs <= 1'b0;
                    if (!phase) begin
                        // Low half of the bit: present data while sck is low.
                        spi_sck <= 1'b0;
                        phase   <= 1'b1;
                        if (bit_cnt == 4'd0) begin
                            shreg    <= load_word;
                            spi_mosi <= load_word[PIXEL_SIZE-1];
                            spi_dc   <= load_dc;
                            if (state == S_PIXEL) begin
                                pix_last <= frame_done;
                            end
                        end else begin
                            spi_mosi <= shreg[PIXEL_SIZE-1];
                        end
                    end else begin
                        // High half of the bit: panel samples on this rising edge.
                        spi_sck <= 1'b1;
                        phase   <= 1'b0;
                        shreg   <= {shreg[PIXEL_SIZE-2:0], 1'b0};
                        // Request the next pixel one clk after capture, unless this is the last.
                        if (state == S_PIXEL && bit_cnt == 4'd0 && !pix_last) begin
                            data_clk <= 1'b1;
                        end
                        if (bit_cnt == last_bit) begin
                            bit_cnt <= 4'd0;
                            case (state)
                                S_SWRESET: begin
                                    state    <= S_WAIT_RST;
                                    wait_cnt <= '0;
                                end
                                S_SLPOUT: begin
                                    state    <= S_WAIT_SLP;
                                    wait_cnt <= '0;
                                end
                                S_CONFIG: begin
                                    if (cfg_idx == CFG_LAST) begin
                                        state    <= S_PRIME;
                                        wait_cnt <= '0;
                                    end else begin
                                        cfg_idx <= cfg_idx + 4'd1;
                                    end
                                end
                                default: begin
                                    if (pix_last) begin
                                        state <= S_DONE;
                                    end
                                end
                            endcase
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end

                S_WAIT_RST: begin
                    spi_cs   <= 1'b1;
                    spi_sck  <= 1'b0;
                    spi_mosi <= 1'b0;
                    if (wait_cnt == RST_LAST) begin
                        state    <= S_SLPOUT;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_WAIT_SLP: begin
                    spi_cs   <= 1'b1;
                    spi_sck  <= 1'b0;
                    spi_mosi <= 1'b0;
                    if (wait_cnt == SLP_LAST) begin
                        state    <= S_CONFIG;
                        cfg_idx  <= 4'd0;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_PRIME: begin
                    // Two idle clks with cs held low: pulse, then give upstream a clk to settle.
                    spi_sck  <= 1'b0;
                    spi_mosi <= 1'b0;
                    if (!wait_cnt[0]) begin
                        data_clk <= 1'b1;
                        wait_cnt <= WAIT_W'(1);
                    end else begin
                        wait_cnt <= '0;
                        bit_cnt  <= 4'd0;
                        phase    <= 1'b0;
                        state    <= S_PIXEL;
                    end
                end

                S_DONE: begin
                    spi_cs   <= 1'b1;
                    spi_sck  <= 1'b0;
                    spi_mosi <= 1'b0;
                    spi_dc   <= 1'b0;
                end

                default: begin
                    state <= S_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ili9341_spi_controller.sv
// Directed bench for ili9341_spi_controller: decodes the SPI pins and serves pixels.
// Latency: checks byte order, wait lengths, data_clk placement and DONE hold.
// Backpressure: upstream model reloads input_data on the falling clk edge after data_clk.
module tb_ili9341_spi_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_done;
    logic [15:0] input_data;
    logic        spi_mosi, spi_sck, spi_cs, spi_dc, data_clk;

    always #5 clk = ~clk;

    ili9341_spi_controller #(
        .PIXEL_SIZE  (16),
        .WIDTH       (128),
        .HEIGHT      (128),
        .SWRESET_WAIT(16),
        .SLPOUT_WAIT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_done(frame_done),
        .input_data(input_data),
        .spi_mosi  (spi_mosi),
        .spi_sck   (spi_sck),
        .spi_cs    (spi_cs),
        .spi_dc    (spi_dc),
        .data_clk  (data_clk)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {dc, byte} expected for the init + window sequence
    logic [8:0] exp_cfg [0:17] = '{
        9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148,
        9'h02A, 9'h100, 9'h100, 9'h100, 9'h17F,
        9'h02B, 9'h100, 9'h100, 9'h100, 9'h17F,
        9'h029, 9'h02C
    };
    logic [8:0] exp_pix_a [0:9] = '{
        9'h1F8, 9'h100, 9'h100, 9'h101, 9'h180, 9'h100, 9'h1FF, 9'h1FF, 9'h112, 9'h134
    };
    logic [8:0] exp_pix_b [0:7] = '{
        9'h100, 9'h101, 9'h180, 9'h100, 9'h1FF, 9'h1FF, 9'h112, 9'h134
    };

    // monitor / upstream state
    int         cyc, rise_cnt, bitpos, last_rise, viol, pulse_cnt, nbytes;
    int         fall_cnt, hi_run, run1, run2, rise_at_p1, rise_at_p2;
    int         n_pix, ptr;
    bit         endless;
    logic       prev_sck, prev_mosi, prev_cs, prev_dclk, byte_dc;
    logic [7:0] cur;
    logic [8:0] log_w [0:63];
    logic [15:0] pix_mem [0:7];

    // Pin decoder and upstream frame-buffer model, evaluated away from the active edge.
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                rise_cnt = 0; bitpos = 0; last_rise = 0; viol = 0; pulse_cnt = 0;
                nbytes = 0; fall_cnt = 0; hi_run = 0; run1 = 0; run2 = 0;
                rise_at_p1 = 0; rise_at_p2 = 0; ptr = 0; cur = 8'h00; byte_dc = 1'b0;
                input_data = 16'h0000; frame_done = 1'b0;
                prev_sck = 1'b0; prev_mosi = 1'b0; prev_cs = 1'b1; prev_dclk = 1'b0;
            end else begin
                if (spi_sck && prev_sck) viol++;
                if (spi_sck && (spi_mosi !== prev_mosi)) viol++;
                if (spi_sck && !prev_sck) begin
                    if (spi_cs) viol++;
                    if (bitpos != 0 && (cyc - last_rise) != 2) viol++;
                    if (bitpos == 0) byte_dc = spi_dc;
                    else if (spi_dc !== byte_dc) viol++;
                    last_rise = cyc;
                    rise_cnt++;
                    cur = {cur[6:0], spi_mosi};
                    bitpos++;
                    if (bitpos == 8) begin
                        bitpos = 0;
                        if (nbytes < 64) log_w[nbytes] = {byte_dc, cur};
                        nbytes++;
                    end
                end
                if (spi_cs) begin
                    hi_run++;
                end else begin
                    if (prev_cs) begin
                        fall_cnt++;
                        if (fall_cnt == 2) run1 = hi_run;
                        if (fall_cnt == 3) run2 = hi_run;
                    end
                    hi_run = 0;
                end
                if (data_clk) begin
                    if (prev_dclk) viol++;
                    pulse_cnt++;
                    if (pulse_cnt == 1) rise_at_p1 = rise_cnt;
                    if (pulse_cnt == 2) rise_at_p2 = rise_cnt;
                    input_data = pix_mem[ptr];
                    frame_done = !endless && (ptr == n_pix - 1);
                    ptr = (ptr + 1) % 8;
                end
                prev_sck  = spi_sck;
                prev_mosi = spi_mosi;
                prev_cs   = spi_cs;
                prev_dclk = data_clk;
            end
        end
    end

    task automatic wait_frame(input int nb);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (nbytes >= nb && spi_cs) break;
        end
        check_eq("frame_len", nbytes, nb);
        check_eq("frame_cs_end", spi_cs, 1'b1);
    endtask

    task automatic check_init_seq();
        for (int i = 0; i < 18; i++) check_eq($sformatf("cfg%0d", i), log_w[i], exp_cfg[i]);
        check_eq("rst_wait_len", run1, 16);
        check_eq("slp_wait_len", run2, 16);
        check_eq("cs_falls", fall_cnt, 3);
        check_eq("prime_pos", rise_at_p1, 144);
        check_eq("pulse2_pos", rise_at_p2, 145);
    endtask

    task automatic check_done_hold();
        int r, p;
        r = rise_cnt;
        p = pulse_cnt;
        repeat (60) @(negedge clk);
        check_eq("done_no_sck", rise_cnt, r);
        check_eq("done_no_dclk", pulse_cnt, p);
        check_eq("done_cs", spi_cs, 1'b1);
        check_eq("done_mosi", spi_mosi, 1'b0);
        check_eq("done_sck", spi_sck, 1'b0);
        check_eq("done_dclk", data_clk, 1'b0);
        check_eq("timing_viol", viol, 0);
    endtask

    initial begin
        bit found;
        // Run A: five pixels, last one flagged
        rst = 1'b0;
        endless = 1'b0;
        n_pix = 5;
        pix_mem[0] = 16'hF800; pix_mem[1] = 16'h0001; pix_mem[2] = 16'h8000;
        pix_mem[3] = 16'hFFFF; pix_mem[4] = 16'h1234; pix_mem[5] = 16'h0000;
        pix_mem[6] = 16'h0000; pix_mem[7] = 16'h0000;
        repeat (3) @(negedge clk);
        check_eq("rst_cs", spi_cs, 1'b1);
        check_eq("rst_sck", spi_sck, 1'b0);
        check_eq("rst_mosi", spi_mosi, 1'b0);
        check_eq("rst_dc", spi_dc, 1'b0);
        check_eq("rst_dclk", data_clk, 1'b0);
        rst = 1'b1;
        wait_frame(28);
        check_init_seq();
        for (int i = 0; i < 10; i++) check_eq($sformatf("pixA%0d", i), log_w[18+i], exp_pix_a[i]);
        check_eq("pulsesA", pulse_cnt, 5);
        check_done_hold();

        // Run B: four pixels, restart from reset
        rst = 1'b0;
        n_pix = 4;
        pix_mem[0] = 16'h0001; pix_mem[1] = 16'h8000; pix_mem[2] = 16'hFFFF; pix_mem[3] = 16'h1234;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_frame(26);
        check_init_seq();
        for (int i = 0; i < 8; i++) check_eq($sformatf("pixB%0d", i), log_w[18+i], exp_pix_b[i]);
        check_eq("pulsesB", pulse_cnt, 4);
        check_done_hold();

        // Run C: endless stream, reset while sck is high mid-pixel
        rst = 1'b0;
        endless = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (rise_cnt >= 170 && spi_sck) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("midrst_reached", found, 1'b1);
        rst = 1'b0;
        #1;
        check_eq("midrst_cs", spi_cs, 1'b1);
        check_eq("midrst_sck", spi_sck, 1'b0);
        check_eq("midrst_mosi", spi_mosi, 1'b0);
        check_eq("midrst_dclk", data_clk, 1'b0);
        repeat (3) @(negedge clk);
        endless = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (nbytes >= 1) break;
        end
        check_eq("restart_bytes", nbytes, 1);
        check_eq("restart_first", log_w[0], 9'h001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
